s_p: RTL and testbench
======================

Name: s_p

Overview:
- Serial-to-parallel converter at the FFT input. It is the front-end counterpart of the output-side parallel-to-serial stage.
- It accepts one complex sample per cycle (34 bits: 17-bit real, 17-bit imaginary) and gathers 16-point frames into a ping-pong buffer.
- Each frame is presented to the first radix-4 butterfly stage as four beats. Each beat carries four stride-4 samples (136 bits).
- Buffer fill and drain overlap, so continuous streaming runs with no stalls.

Parameters:
DATA_W, 34, width of one complex sample; output width is 4*DATA_W.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
data_in  input  DATA_W  serial input sample.
in_valid  input  1  data_in valid this cycle.
in_sop  input  1  with in_valid: this sample is index 0 of a new frame.
data_out  output  4*DATA_W  parallel beat; lane j at bits [(j+1)*DATA_W-1 : j*DATA_W].
out_valid  output  1  data_out valid this cycle.
out_sop  output  1  first beat of a frame (qualified by out_valid).

Behaviour:
- Reset (rst=1 at a rising edge, synchronous, active-high):
  - wr_cnt=0, wr_bank=0, rd_bank=0, full[1:0]=00, rd_cnt=0, state=IDLE.
  - out_valid=0, out_sop=0, data_out=0.
  - Buffer storage is not reset.
  - Reset mid-frame discards the partial frame and any pending or in-progress drain.
- Storage: two banks of 16 x DATA_W, bank[b][i] = sample x[i].
- Write side, on each cycle with in_valid=1:
  - Write index idx = in_sop ? 0 : wr_cnt.
  - bank[wr_bank][idx] <= data_in; wr_cnt <= idx+1 (4-bit).
  - On idx==15: wr_cnt wraps to 0, wr_bank toggles, full[wr_bank] <= 1.
- Write-side boundaries:
  - in_sop with in_valid=0 is ignored.
  - in_sop mid-frame: the earlier partial samples are abandoned and never output. The frame restarts in the same bank.
  - in_valid=0 cycles are gaps; wr_cnt holds.
- Read FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when full[rd_bank]=1. rd_cnt=0.
  - In DRAIN, each cycle registers:
    - data_out lane j <= bank[rd_bank][rd_cnt + 4*j] for j=0..3, so lane0=x[k], lane1=x[k+4], lane2=x[k+8], lane3=x[k+12], k=rd_cnt.
    - out_valid <= 1; out_sop <= (rd_cnt==0); rd_cnt++.
  - After rd_cnt==3: full[rd_bank] <= 0 and rd_bank toggles.
  - If the other bank is already full, stay in DRAIN with rd_cnt=0 (back-to-back beats). Otherwise go to IDLE.
- IDLE outputs: out_valid=0, out_sop=0, data_out holds its last value.
- Set/clear on the same edge: if a full flag is set and cleared on the same edge (different banks), both take effect.
- Latency: if the index-15 sample is accepted in cycle T, beats appear in cycles T+2..T+5. out_valid is high for exactly 4 consecutive cycles per frame.
- Overflow: unreachable by construction. Fill takes at least 16 cycles and drain takes at most 4 cycles plus latency, so a bank is never written while its full flag is set. The bench asserts this as a property.
- Width: data is passed through unmodified; there is no arithmetic.

Test Plan:
1. Single frame, x[i]=i for i=0..15, contiguous, in_sop on i=0 -> cycles T+2..T+5 give data_out lanes {3,2,1,0} = {12,8,4,0}, {13,9,5,1}, {14,10,6,2}, {15,11,7,3}. out_sop=1 only in T+2; out_valid=0 at T+6.
2. Three back-to-back frames with x=frame*16+i, in_valid constantly 1 -> 12 beats in 3 groups of 4, groups starting 16 cycles apart. Correct stride-4 order in each group, no dropped or duplicated samples, full never 11 at a write.
3. in_valid toggling 1,0,1,0 across one frame -> identical output values to scenario 1. First beat 2 cycles after the final accepted sample.
4. in_sop asserted at write index 9 of a frame (partial samples 100..108), then 16 samples 0..15 -> only one 4-beat group, matching scenario 1. No beat contains 100..108.
5. rst=1 for one cycle during the second beat of a drain -> next cycle out_valid=0, out_sop=0, data_out=0. The interrupted frame is never output; a following full frame outputs per scenario 1.
6. in_sop=1 with in_valid=0 at write index 5, then the frame continues -> ignored; the frame completes at the 16th valid sample and outputs normally.

Source files
------------

// File: rtl/s_p.sv
// rtl/s_p.sv - serial-to-parallel ping-pong framer feeding the first radix-4 stage
module s_p #(
    parameter int DATA_W = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  in_valid,
    input  logic                  in_sop,
    output logic [4*DATA_W-1:0]   data_out,
    output logic                  out_valid,
    output logic                  out_sop
);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [DATA_W-1:0]   mem [2][16];
    logic [3:0]          wr_cnt;
    logic [3:0]          wr_idx;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic [1:0]          rd_cnt;
    state_t              state;
    logic                rd_go;
    logic [1:0]          set_mask;
    logic [1:0]          clr_mask;
    logic [4*DATA_W-1:0] rd_beat;

    assign wr_idx = in_sop ? 4'd0 : wr_cnt;

    // A full bank is drained starting on the very edge it is seen, so the
    // first beat lands two cycles after the closing sample.
    assign rd_go = (state == DRAIN) || full[rd_bank];

    assign set_mask = (in_valid && wr_idx == 4'd15) ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = (rd_go && rd_cnt == 2'd3) ? (2'b01 << rd_bank) : 2'b00;

    always_comb begin
        rd_beat = '0;
        for (int j = 0; j < 4; j++) begin
            rd_beat[j*DATA_W +: DATA_W] = mem[rd_bank][4'(4*j) + {2'b00, rd_cnt}];
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_bank][wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            rd_cnt    <= '0;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            data_out  <= '0;
        end else begin
            full <= (full & ~clr_mask) | set_mask;

            if (in_valid) begin
                wr_cnt <= wr_idx + 4'd1;
                if (wr_idx == 4'd15) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (rd_go) begin
                data_out  <= rd_beat;
                out_valid <= 1'b1;
                out_sop   <= (rd_cnt == 2'd0);
                rd_cnt    <= rd_cnt + 2'd1;
                if (rd_cnt == 2'd3) begin
                    rd_bank <= ~rd_bank;
                    state   <= full[~rd_bank] ? DRAIN : IDLE;
                end else begin
                    state   <= DRAIN;
                end
            end else begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_s_p.sv
// tb/tb_s_p.sv - scoreboard bench for the s_p serial-to-parallel framer
module tb_s_p;

    localparam int DW = 34;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   data_in;
    logic            in_valid;
    logic            in_sop;
    logic [4*DW-1:0] data_out;
    logic            out_valid;
    logic            out_sop;

    s_p #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_sop  (out_sop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4*DW-1:0] data;
        logic            sop;
        int              cyc;
    } beat_t;

    beat_t         sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] fbuf[16];
    int            m_wr  = 0;

    // Drive one cycle; the reference model tracks the write index and
    // queues the four stride-4 beats once a frame closes.
    task automatic drive(input logic [DW-1:0] d, input logic v, input logic s);
        int    idx;
        beat_t b;
        data_in  = d;
        in_valid = v;
        in_sop   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        if (v) begin
            idx = s ? 0 : m_wr;
            fbuf[idx] = d;
            m_wr = (idx + 1) % 16;
            if (idx == 15) begin
                for (int k = 0; k < 4; k++) begin
                    b.data = {fbuf[k+12], fbuf[k+8], fbuf[k+4], fbuf[k]};
                    b.sop  = (k == 0);
                    b.cyc  = cyc + 1 + k;
                    sb.push_back(b);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 16; i++) drive(DW'(base + i), 1'b1, i == 0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && in_valid && dut.full[dut.wr_bank]) begin
            bad++;
            $display("FAIL overflow: write to bank %0d while full=%b", dut.wr_bank, dut.full);
        end
        if (out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: cycle %0d data %h, no beat required", cyc, data_out);
            end else begin
                e = sb.pop_front();
                if (data_out !== e.data) begin
                    bad++;
                    $display("FAIL beat_data: got %h want %h", data_out, e.data);
                end
                total++;
                if (out_sop !== e.sop) begin
                    bad++;
                    $display("FAIL beat_sop: got %b want %b", out_sop, e.sop);
                end
                total++;
                if (cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL beat_cycle: got %0d want %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drain_check(input string name);
        idle(8);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_beats: got %0d outstanding want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_sop !== 1'b0)   begin bad++; $display("FAIL reset_sop: got %b want 0", out_sop); end
        if (data_out !== '0)    begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
        rst  = 1'b0;
        m_wr = 0;
        idle(2);
    endtask

    task automatic test_single;
        send_frame(0);
        drain_check("single");
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 3; f++) send_frame(f * 16);
        drain_check("back_to_back");
    endtask

    task automatic test_gaps;
        for (int i = 0; i < 16; i++) begin
            drive(DW'(i), 1'b1, i == 0);
            if (i < 15) drive(DW'(999), 1'b0, 1'b0);
        end
        drain_check("gaps");
    endtask

    task automatic test_sop_restart;
        for (int i = 0; i < 9; i++) drive(DW'(100 + i), 1'b1, i == 0);
        send_frame(0);
        drain_check("sop_restart");
    endtask

    task automatic test_sop_no_valid;
        for (int i = 0; i < 5; i++) drive(DW'(i), 1'b1, i == 0);
        drive(DW'(77), 1'b0, 1'b1);
        for (int i = 5; i < 16; i++) drive(DW'(i), 1'b1, 1'b0);
        drain_check("sop_no_valid");
    endtask

    task automatic test_reset_mid_drain;
        send_frame(0);
        idle(2);
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        rst = 1'b0;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        if (out_sop !== 1'b0)   begin bad++; $display("FAIL mid_reset_sop: got %b want 0", out_sop); end
        if (data_out !== '0)    begin bad++; $display("FAIL mid_reset_data: got %h want 0", data_out); end
        sb.delete();
        m_wr = 0;
        idle(6);
        send_frame(0);
        drain_check("after_reset");
    endtask

    task automatic test_random;
        logic [DW-1:0] v;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                v = {2'($urandom_range(3, 0)), 32'($urandom)};
                drive(v, 1'b1, i == 0);
            end
        end
        drain_check("random");
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_gaps;
        test_sop_restart;
        test_sop_no_valid;
        test_reset_mid_drain;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
